// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions used by the fetch stage and its IF/ID register.
//   PC_W      : width of a word address into instruction memory
//   INSTR_W   : instruction width
//   NOP_INSTR : encoding injected as a bubble
//   fetch_state_t : fetch-control FSM states
//   pc_inc()  : word-address increment, wrapping modulo 2**PC_W
package pipeline_pkg;

  localparam int PC_W    = 11;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  // BOOT : first cycle(s) after reset, nothing requested yet
  // RUN  : normal streaming
  // HOLD : stalled with a returned word parked in the hold buffer
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/if_id.sv
// IF/ID pipeline register.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load           : capture data/pc/valid this edge
//   flush          : force a bubble (NOP, pc 0, invalid); wins over load
//   data, pc, valid: next contents
//   instruction, current_pc, instr_valid : registered outputs to decode
module if_id
  import pipeline_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] data,
  input  logic [PC_W-1:0]    pc,
  input  logic               valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    current_pc,
  output logic               instr_valid
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instruction <= NOP_INSTR;
      current_pc  <= '0;
      instr_valid <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INSTR;
      current_pc  <= '0;
      instr_valid <= 1'b0;
    end else if (load) begin
      instruction <= data;
      current_pc  <= pc;
      instr_valid <= valid;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives a PC into a synchronous instruction memory
// (read data one cycle after the strobe) and registers the returned word,
// together with its address + 1, into the IF/ID register.
// A stall freezes the PC and the IF/ID register; a word that returns while
// stalled is parked in a one-entry hold buffer and delivered first on
// release. branch_taken overrides stall, redirects the PC and flushes.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   stall                   : hold request from downstream
//   branch_taken            : redirect request
//   jump_dest_addr[10:0]    : redirect target word address
//   imem_addr[10:0]         : memory read address (= PC register)
//   imem_rd_en              : memory read strobe
//   imem_data[31:0]         : memory read data, one cycle after imem_rd_en
//   instruction[31:0]       : registered instruction to decode
//   current_pc[10:0]        : registered fetched address + 1
//   instr_valid             : instruction/current_pc hold a real fetch
//   stall_cycles[15:0]      : saturating stall counter, present only when
//                             the macro IF_STALL_CNT_EN is defined
module instruction_fetch
  import pipeline_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 11'd0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    jump_dest_addr,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd_en,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    current_pc,
  output logic               instr_valid
`ifdef IF_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  fetch_state_t state, state_next;

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    req_pc;
  logic               req_valid;
  logic [INSTR_W-1:0] hold_data;
  logic [PC_W-1:0]    hold_pc;
  logic               hold_valid;

  logic               issue;
  logic               capture;
  logic               ifid_load;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_data;
  logic [PC_W-1:0]    ifid_pc;
  logic               ifid_valid;

  assign imem_addr  = pc_q;
  // The strobe is gated by reset so memory sees no request while held in reset.
  assign imem_rd_en = issue & reset_n;

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    capture    = 1'b0;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_data  = NOP_INSTR;
    ifid_pc    = '0;
    ifid_valid = 1'b0;

    if (branch_taken) begin
      ifid_flush = 1'b1;
      state_next = RUN;
    end else if (stall) begin
      // A response in flight must be caught now; memory will not repeat it.
      capture = req_valid;
      if (req_valid) begin
        state_next = HOLD;
      end
    end else begin
      issue      = 1'b1;
      ifid_load  = 1'b1;
      state_next = RUN;
      // hold_valid and req_valid are never both set: capture clears the
      // request and no new request issues while stalled.
      if (hold_valid) begin
        ifid_data  = hold_data;
        ifid_pc    = pc_inc(hold_pc);
        ifid_valid = 1'b1;
      end else if (req_valid) begin
        ifid_data  = imem_data;
        ifid_pc    = pc_inc(req_pc);
        ifid_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      req_valid  <= 1'b0;
      hold_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (branch_taken) begin
        pc_q       <= jump_dest_addr;
        req_valid  <= 1'b0;
        hold_valid <= 1'b0;
      end else if (issue) begin
        pc_q       <= pc_inc(pc_q);
        req_valid  <= 1'b1;
        hold_valid <= 1'b0;
      end else if (capture) begin
        req_valid  <= 1'b0;
        hold_valid <= 1'b1;
      end
    end
  end

  // Address/data payloads are qualified by req_valid/hold_valid and need no reset.
  always_ff @(posedge clock) begin
    if (issue) begin
      req_pc <= pc_q;
    end
    if (capture) begin
      hold_data <= imem_data;
      hold_pc   <= req_pc;
    end
  end

  if_id u_if_id (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (ifid_load),
    .flush       (ifid_flush),
    .data        (ifid_data),
    .pc          (ifid_pc),
    .valid       (ifid_valid),
    .instruction (instruction),
    .current_pc  (current_pc),
    .instr_valid (instr_valid)
  );

`ifdef IF_STALL_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall && !branch_taken && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed vector table, hand-written
// reset-during-stall sequence, and randomized traffic against a queue-based
// reference model. Memory contents are a fixed function of the address.
module tb_instruction_fetch;

  localparam logic [10:0] RST_PC = 11'd0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [10:0] jump_dest_addr = '0;
  logic [10:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data = '0;
  logic [31:0] instruction;
  logic [10:0] current_pc;
  logic        instr_valid;
`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .jump_dest_addr (jump_dest_addr),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_data      (imem_data),
    .instruction    (instruction),
    .current_pc     (current_pc),
    .instr_valid    (instr_valid)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  // Never zero, distinct per address, so a NOP can never pass for a word.
  function automatic logic [31:0] memval(input logic [10:0] a);
    return {5'h13, a, 5'h0A, ~a};
  endfunction

  always @(posedge clock) begin
    if (imem_rd_en) imem_data <= memval(imem_addr);
  end

  // Reference model: a queue of addresses requested but not yet delivered.
  logic [10:0] m_pc;
  int          m_q[$];
  logic [31:0] m_instr;
  logic [10:0] m_cpc;
  logic        m_valid;
  int          m_stalls;

  task automatic model_reset();
    m_pc = RST_PC;
    m_q.delete();
    m_instr = 32'h0;
    m_cpc = 11'd0;
    m_valid = 1'b0;
    m_stalls = 0;
  endtask

  task automatic model_step(input bit st, input bit br, input logic [10:0] j);
    if (br) begin
      m_pc = j;
      m_q.delete();
      m_instr = 32'h0;
      m_cpc = 11'd0;
      m_valid = 1'b0;
    end else if (st) begin
      if (m_stalls < 65535) m_stalls++;
    end else begin
      if (m_q.size() > 0) begin
        int a;
        a = m_q.pop_front();
        m_instr = memval(a[10:0]);
        m_cpc = 11'((a + 1) % 2048);
        m_valid = 1'b1;
      end else begin
        m_instr = 32'h0;
        m_valid = 1'b0;
      end
      m_q.push_back(int'(m_pc));
      m_pc = 11'((int'(m_pc) + 1) % 2048);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs after the falling edge, sample the combinational address
  // side, then step through the rising edge and return 1 time unit later.
  task automatic cyc(input bit st, input bit br, input logic [10:0] j,
                     output logic [10:0] a, output logic rd);
    @(negedge clock);
    stall = st;
    branch_taken = br;
    jump_dest_addr = j;
    #1;
    a = imem_addr;
    rd = imem_rd_en;
    @(posedge clock);
    #1;
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, release just
  // after a rising edge so the next cycle is the first active one.
  task automatic do_reset();
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_instruction", instruction, 32'h0);
    chk("rst_current_pc", current_pc, 32'h0);
    chk("rst_instr_valid", instr_valid, 32'h0);
    chk("rst_imem_rd_en", imem_rd_en, 32'h0);
    chk("rst_imem_addr", imem_addr, RST_PC);
`ifdef IF_STALL_CNT_EN
    chk("rst_stall_cycles", stall_cycles, 32'h0);
`endif
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          st;
    bit          br;
    logic [10:0] j;
    logic [10:0] ea;
    bit          erd;
    int          ew;   // address of expected word after the edge, -1 = bubble
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [10:0] a;
    logic        rd;
    string       tag;

    tbl[0]  = '{0, 0, 11'h000, 11'h000, 1, -1};
    tbl[1]  = '{0, 0, 11'h000, 11'h001, 1, 0};
    tbl[2]  = '{0, 0, 11'h000, 11'h002, 1, 1};
    tbl[3]  = '{0, 0, 11'h000, 11'h003, 1, 2};
    tbl[4]  = '{0, 0, 11'h000, 11'h004, 1, 3};
    tbl[5]  = '{0, 0, 11'h000, 11'h005, 1, 4};
    tbl[6]  = '{1, 0, 11'h000, 11'h006, 0, 4};
    tbl[7]  = '{1, 0, 11'h000, 11'h006, 0, 4};
    tbl[8]  = '{1, 0, 11'h000, 11'h006, 0, 4};
    tbl[9]  = '{0, 0, 11'h000, 11'h006, 1, 5};
    tbl[10] = '{0, 0, 11'h000, 11'h007, 1, 6};
    tbl[11] = '{0, 1, 11'h100, 11'h008, 0, -1};
    tbl[12] = '{0, 0, 11'h000, 11'h100, 1, -1};
    tbl[13] = '{0, 0, 11'h000, 11'h101, 1, 'h100};
    tbl[14] = '{0, 0, 11'h000, 11'h102, 1, 'h101};
    tbl[15] = '{1, 0, 11'h000, 11'h103, 0, 'h101};
    tbl[16] = '{1, 1, 11'h7FE, 11'h103, 0, -1};
    tbl[17] = '{0, 0, 11'h000, 11'h7FE, 1, -1};
    tbl[18] = '{0, 0, 11'h000, 11'h7FF, 1, 'h7FE};
    tbl[19] = '{0, 0, 11'h000, 11'h000, 1, 'h7FF};
    tbl[20] = '{0, 0, 11'h000, 11'h001, 1, 0};

    // Directed table
    do_reset();
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].st, tbl[i].br, tbl[i].j, a, rd);
      tag = $sformatf("vec%0d", i);
      chk({tag, "_imem_addr"}, a, tbl[i].ea);
      chk({tag, "_imem_rd_en"}, rd, tbl[i].erd);
      chk({tag, "_instr_valid"}, instr_valid, (tbl[i].ew >= 0) ? 1 : 0);
      if (tbl[i].ew >= 0) begin
        chk({tag, "_instruction"}, instruction, memval(11'(tbl[i].ew)));
        chk({tag, "_current_pc"}, current_pc, (tbl[i].ew + 1) % 2048);
      end else begin
        chk({tag, "_instruction"}, instruction, 32'h0);
      end
    end

    // Reset asserted while stalled with a parked word
    cyc(1, 0, 11'h0, a, rd);
    cyc(1, 0, 11'h0, a, rd);
    chk("pre_rst_held_word", instruction, memval(11'h000));
    do_reset();
    cyc(0, 0, 11'h0, a, rd);
    chk("post_rst_addr0", a, RST_PC);
    chk("post_rst_bubble", instr_valid, 32'h0);
    cyc(0, 0, 11'h0, a, rd);
    chk("post_rst_addr1", a, 11'(RST_PC + 11'd1));
    chk("post_rst_valid", instr_valid, 32'h1);
    chk("post_rst_word", instruction, memval(RST_PC));
    chk("post_rst_cpc", current_pc, 11'(RST_PC + 11'd1));

    // Randomized traffic against the model
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      bit          st;
      bit          br;
      logic [10:0] j;
      if (i == 200) begin
        do_reset();
        model_reset();
      end
      st = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 8);
      j  = ($urandom_range(0, 3) == 0) ? 11'(11'h7FD + 11'($urandom_range(0, 2)))
                                       : 11'($urandom);
      cyc(st, br, j, a, rd);
      chk("rnd_imem_addr", a, m_pc);
      chk("rnd_imem_rd_en", rd, (!st && !br) ? 1 : 0);
      model_step(st, br, j);
      chk("rnd_instr_valid", instr_valid, m_valid);
      chk("rnd_instruction", instruction, m_instr);
      if (m_valid) chk("rnd_current_pc", current_pc, m_cpc);
    end
`ifdef IF_STALL_CNT_EN
    chk("rnd_stall_cycles", stall_cycles, m_stalls);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 11'd0: word address fetched first after reset.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port stall, input, 1: hazard hold request from downstream.
REQ-005 SHALL have port branch_taken, input, 1: redirect request from decode.
REQ-006 SHALL have port jump_dest_addr, input, 11: redirect target word address.
REQ-007 SHALL have port imem_addr, output, 11: instruction memory read address.
REQ-008 SHALL have port imem_rd_en, output, 1: instruction memory read strobe.
REQ-009 SHALL have port imem_data, input, 32: read data, valid exactly one cycle after imem_rd_en.
REQ-010 SHALL have port instruction, output, 32: registered instruction to decode.
REQ-011 SHALL have port current_pc, output, 11: registered address of fetched word plus 1.
REQ-012 SHALL have port instr_valid, output, 1: high when instruction/current_pc hold a real fetch.

Function
REQ-013 SHALL keep 11-bit PC register pc_q; imem_addr = pc_q combinationally.
REQ-014 SHALL assert imem_rd_en when stall=0 and branch_taken=0, and SHALL then advance pc_q by 1 and record req_pc=pc_q, req_valid=1.
REQ-015 SHALL wrap pc_q from 2047 to 0 with no flag.
REQ-016 SHALL load the IF/ID register (instruction=imem_data, current_pc=req_pc+1 mod 2048, instr_valid=1) at an edge with stall=0, branch_taken=0, req_valid=1; with req_valid=0 it SHALL load NOP (32'h0), instr_valid=0.
REQ-017 SHALL give 2-cycle latency: address presented in cycle t appears at instruction in cycle t+2.
REQ-018 SHALL, during stall=1, deassert imem_rd_en and hold pc_q and the IF/ID register unchanged.
REQ-019 SHALL, if a response arrives while stalled (req_valid=1), capture it into a one-entry hold buffer (hold_valid=1, req_valid=0); on stall release the IF/ID register SHALL take the hold buffer contents before any newer response, clearing hold_valid.
REQ-020 SHALL use FSM states BOOT (first cycle after reset, no response pending), RUN, HOLD (stalled with buffered word); BOOT->RUN on first issued fetch, RUN->HOLD on stall with pending response, HOLD->RUN on stall release, any state->RUN on branch_taken.
REQ-021 SHALL give branch_taken priority over stall: pc_q=jump_dest_addr, req_valid=0, hold_valid=0, IF/ID loaded with NOP and instr_valid=0, imem_rd_en=0 that cycle.
REQ-022 SHALL never emit the same fetched word twice, nor drop one, across any stall sequence.

Reset
REQ-023 SHALL on reset_n=0 immediately set pc_q=RESET_PC, instruction=32'h0, current_pc=0, instr_valid=0, req_valid=0, hold_valid=0, state=BOOT; imem_rd_en=0 while reset_n=0.
REQ-024 SHALL discard any in-flight memory response when reset is asserted mid-operation.

Configuration
REQ-025 SHALL, with IF_STALL_CNT_EN defined, add output stall_cycles (16 bits), reset to 0, incremented each cycle with stall=1 and branch_taken=0, saturating at 16'hFFFF.
REQ-026 SHALL, without IF_STALL_CNT_EN, omit the stall_cycles port and counter entirely.

Structure
REQ-027 SHALL take PC_W=11, INSTR_W=32, NOP_INSTR=32'h0 and the FSM state enum from shared package pipeline_pkg.
REQ-028 SHALL implement the IF/ID pipeline register as sub-module if_id (data, pc, valid, load, flush).

Verification
REQ-029 SHALL cover: reset release with RESET_PC=0 -> imem_addr 0,1,2; instruction at cycle 2 = mem[0], current_pc=1, instr_valid=1.
REQ-030 SHALL cover: stall 3 cycles after fetching addr 5 -> output holds mem[4]; after release outputs mem[5], mem[6] in order, none skipped or duplicated.
REQ-031 SHALL cover: branch_taken with jump_dest_addr=11'h100 -> one NOP bubble (instr_valid=0), then imem_addr=0x100 and mem[0x100] two cycles later.
REQ-032 SHALL cover: branch_taken and stall together -> redirect to target taken, hold buffer cleared.
REQ-033 SHALL cover: pc_q=2047 -> next imem_addr=0, current_pc for word 2047 equals 0.
REQ-034 SHALL cover: reset_n low mid-stall with hold_valid=1 -> all outputs at reset values asynchronously; first post-reset output = mem[RESET_PC].
